// File: rtl/serial_comp_pkg.sv
// serial_comp_pkg: shared types and helpers for the bit-serial magnitude
// comparator. Holds the FSM state encoding, the relation encoding and the
// mapping from a relation to the {l,g,e} flag triple.
package serial_comp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REL_EQ = 2'd0,
        REL_LT = 2'd1,
        REL_GT = 2'd2
    } rel_t;

    // Map a relation onto the {l,g,e} triple; exactly one bit is set.
    function automatic logic [2:0] rel_to_lge(input rel_t rel);
        logic [2:0] lge;
        case (rel)
            REL_LT:  lge = 3'b100;
            REL_GT:  lge = 3'b010;
            default: lge = 3'b001;
        endcase
        return lge;
    endfunction

endpackage

// File: rtl/serial_comp.sv
// serial_comp: bit-serial magnitude comparator. Two WIDTH-bit operands
// arrive MSB first, one bit pair per cycle with bit_valid high. The first
// differing pair decides the relation, which then stays frozen. l/g/e are
// loaded on the edge entering DONE and hold until the next comparison ends.
// Optional build macro SERIAL_COMP_SIGNED_EN: treat operands as two's
// complement, so a differing sign bit inverts the unsigned decision.
module serial_comp
    import serial_comp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic done,
    output logic l,
    output logic g,
    output logic e
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    rel_t          rel_q,   rel_d;
    logic [2:0]    lge_q,   lge_d;
    rel_t          rel_next;

    // Relation update for the bit pair currently presented; only an
    // undecided relation can change, and only on a differing pair.
    always_comb begin
        rel_next = rel_q;
        if (rel_q == REL_EQ && a_bit != b_bit) begin
`ifdef SERIAL_COMP_SIGNED_EN
            if (cnt_q == '0) begin
                rel_next = a_bit ? REL_LT : REL_GT;
            end else begin
                rel_next = a_bit ? REL_GT : REL_LT;
            end
`else
            rel_next = a_bit ? REL_GT : REL_LT;
`endif
        end
    end

    // Next-state, counter, relation and result flag computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rel_d   = rel_q;
        lge_d   = lge_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    rel_d   = REL_EQ;
                end
            end
            RUN: begin
                if (bit_valid) begin
                    rel_d = rel_next;
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                        lge_d   = rel_to_lge(rel_next);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, relation and result registers; reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rel_q   <= REL_EQ;
            lge_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
            lge_q   <= lge_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign l    = lge_q[2];
    assign g    = lge_q[1];
    assign e    = lge_q[0];

endmodule

// File: tb/tb_serial_comp.sv
// tb_serial_comp: scoreboard bench for serial_comp (WIDTH=8). Expected
// flags and done latency are pushed when a comparison is started and
// popped when done is observed. Honours SERIAL_COMP_SIGNED_EN for the
// reference model.
module tb_serial_comp;

    localparam int WIDTH = 8;

    typedef struct {
        logic [2:0] lge;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic bit_valid;
    logic a_bit;
    logic b_bit;
    logic busy;
    logic done;
    logic l;
    logic g;
    logic e;

    exp_t sb_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   tb_cyc    = 0;
    int   start_cyc = 0;

    serial_comp #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bit_valid(bit_valid),
        .a_bit    (a_bit),
        .b_bit    (b_bit),
        .busy     (busy),
        .done     (done),
        .l        (l),
        .g        (g),
        .e        (e)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    // Reference comparison of two full operands.
    function automatic logic [2:0] ref_lge(input logic [7:0] a, input logic [7:0] b);
        logic [2:0] r;
`ifdef SERIAL_COMP_SIGNED_EN
        if ($signed(a) < $signed(b))      r = 3'b100;
        else if ($signed(a) > $signed(b)) r = 3'b010;
        else                              r = 3'b001;
`else
        if (a < b)      r = 3'b100;
        else if (a > b) r = 3'b010;
        else            r = 3'b001;
`endif
        return r;
    endfunction

    // Drive one comparison: start, then WIDTH bits MSB first. Cycle 1 is
    // the start cycle; gap_mask[c] forces bit_valid low on cycle c.
    task automatic drive_compare(input logic [7:0] a, input logic [7:0] b,
                                 input logic [31:0] gap_mask,
                                 input bit start_in_run, input bit junk_in_idle);
        int c;
        int i;
        @(posedge clk); #1;
        start     = 1'b1;
        start_cyc = tb_cyc;
        if (junk_in_idle) begin
            bit_valid = 1'b1;
            a_bit     = 1'b1;
            b_bit     = 1'b0;
        end
        @(posedge clk); #1;
        start     = 1'b0;
        bit_valid = 1'b0;
        c = 2;
        i = WIDTH - 1;
        while (i >= 0) begin
            if (gap_mask[c]) begin
                bit_valid = 1'b0;
                a_bit     = ~a_bit;
                b_bit     = a_bit;
            end else begin
                bit_valid = 1'b1;
                a_bit     = a[i];
                b_bit     = b[i];
                i--;
            end
            start = start_in_run && (c == 4);
            @(posedge clk); #1;
            c++;
        end
        bit_valid = 1'b0;
        start     = 1'b0;
    endtask

    // Wait (bounded) for a done pulse; reports whether seen and its latency.
    task automatic wait_done(output bit got, output int lat);
        got = 1'b0;
        lat = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                lat = tb_cyc - start_cyc + 1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        bit_valid = 1'b0;
        a_bit     = 1'b0;
        b_bit     = 1'b0;
        #12;
        checks++;
        if ({busy, done, l, g, e} !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%b expected=00000", {busy, done, l, g, e});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL idle_after_reset got=%b expected=00", {busy, done});
        end
    endtask

    task automatic test_equal();
        exp_t x;
        bit   got;
        int   lat;
        logic [2:0] held;
        sb_q.push_back('{lge: 3'b001, lat: WIDTH + 2});
        drive_compare(8'hA5, 8'hA5, 32'h0, 1'b0, 1'b0);
        wait_done(got, lat);
        x = sb_q.pop_front();
        checks++;
        if (!got) begin
            failures++;
            $display("[TB] FAIL equal_done_timeout got=none expected=done");
        end else begin
            if ({l, g, e} !== x.lge) begin
                failures++;
                $display("[TB] FAIL equal_lge got=%b expected=%b", {l, g, e}, x.lge);
            end
            checks++;
            if (lat !== x.lat) begin
                failures++;
                $display("[TB] FAIL equal_latency got=%0d expected=%0d", lat, x.lat);
            end
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL busy_in_done got=%b expected=0", busy);
            end
            held = {l, g, e};
            @(negedge clk);
            checks++;
            if ({done, l, g, e} !== {1'b0, held}) begin
                failures++;
                $display("[TB] FAIL done_pulse_hold got=%b expected=%b", {done, l, g, e}, {1'b0, held});
            end
        end
    endtask

    task automatic test_sign_msb();
        logic [7:0] av[2];
        logic [7:0] bv[2];
        exp_t x;
        bit   got;
        int   lat;
        av[0] = 8'h80; bv[0] = 8'h7F;
        av[1] = 8'hFF; bv[1] = 8'h01;
        for (int n = 0; n < 2; n++) begin
            sb_q.push_back('{lge: ref_lge(av[n], bv[n]), lat: WIDTH + 2});
            drive_compare(av[n], bv[n], 32'h0, 1'b0, 1'b0);
            wait_done(got, lat);
            x = sb_q.pop_front();
            checks++;
            if (!got) begin
                failures++;
                $display("[TB] FAIL sign_done_timeout case=%0d got=none expected=done", n);
            end else if ({l, g, e} !== x.lge) begin
                failures++;
                $display("[TB] FAIL sign_lge case=%0d got=%b expected=%b", n, {l, g, e}, x.lge);
            end
        end
    endtask

    task automatic test_stall();
        exp_t x;
        bit   got;
        int   lat;
        sb_q.push_back('{lge: ref_lge(8'h3C, 8'h3D), lat: WIDTH + 2 + 3});
        drive_compare(8'h3C, 8'h3D, 32'h0000_0064, 1'b0, 1'b0);
        wait_done(got, lat);
        x = sb_q.pop_front();
        checks++;
        if (!got) begin
            failures++;
            $display("[TB] FAIL stall_done_timeout got=none expected=done");
        end else begin
            if ({l, g, e} !== x.lge) begin
                failures++;
                $display("[TB] FAIL stall_lge got=%b expected=%b", {l, g, e}, x.lge);
            end
            checks++;
            if (lat !== x.lat) begin
                failures++;
                $display("[TB] FAIL stall_latency got=%0d expected=%0d", lat, x.lat);
            end
        end
    endtask

    task automatic test_abort_reset();
        exp_t x;
        bit   got;
        int   lat;
        bit   saw_done;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bit_valid = 1'b1;
            a_bit     = 1'b1;
            b_bit     = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL busy_in_run got=%b expected=1", busy);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, l, g, e} !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL abort_reset_outputs got=%b expected=00000", {busy, done, l, g, e});
        end
        bit_valid = 1'b0;
        saw_done  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("[TB] FAIL abort_no_done got=done expected=none");
        end
        sb_q.push_back('{lge: 3'b100, lat: WIDTH + 2});
        drive_compare(8'h01, 8'h02, 32'h0, 1'b0, 1'b0);
        wait_done(got, lat);
        x = sb_q.pop_front();
        checks++;
        if (!got) begin
            failures++;
            $display("[TB] FAIL fresh_done_timeout got=none expected=done");
        end else if ({l, g, e} !== x.lge) begin
            failures++;
            $display("[TB] FAIL fresh_lge got=%b expected=%b", {l, g, e}, x.lge);
        end
    endtask

    task automatic test_extra_start();
        exp_t x;
        bit   got;
        int   lat;
        sb_q.push_back('{lge: 3'b100, lat: WIDTH + 2});
        drive_compare(8'h10, 8'h20, 32'h0, 1'b1, 1'b1);
        wait_done(got, lat);
        x = sb_q.pop_front();
        checks++;
        if (!got) begin
            failures++;
            $display("[TB] FAIL extra_done_timeout got=none expected=done");
        end else begin
            if ({l, g, e} !== x.lge) begin
                failures++;
                $display("[TB] FAIL extra_lge got=%b expected=%b", {l, g, e}, x.lge);
            end
            checks++;
            if (lat !== x.lat) begin
                failures++;
                $display("[TB] FAIL extra_latency got=%0d expected=%0d", lat, x.lat);
            end
            @(negedge clk);
            @(negedge clk);
            checks++;
            if ({busy, done} !== 2'b00) begin
                failures++;
                $display("[TB] FAIL extra_idle_after got=%b expected=00", {busy, done});
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t x;
        bit   got;
        int   lat;
        logic [7:0] a;
        logic [7:0] b;
        for (int n = 0; n < 4; n++) begin
            a = 8'($urandom_range(0, 255));
            b = (n == 1) ? a : 8'($urandom_range(0, 255));
            sb_q.push_back('{lge: ref_lge(a, b), lat: WIDTH + 2});
            drive_compare(a, b, 32'h0, 1'b0, 1'b0);
            wait_done(got, lat);
            x = sb_q.pop_front();
            checks++;
            if (!got) begin
                failures++;
                $display("[TB] FAIL b2b_done_timeout case=%0d got=none expected=done", n);
            end else begin
                if ({l, g, e} !== x.lge) begin
                    failures++;
                    $display("[TB] FAIL b2b_lge case=%0d a=%h b=%h got=%b expected=%b", n, a, b, {l, g, e}, x.lge);
                end
                checks++;
                if (lat !== x.lat) begin
                    failures++;
                    $display("[TB] FAIL b2b_latency case=%0d got=%0d expected=%0d", n, lat, x.lat);
                end
            end
        end
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        test_reset();
        test_equal();
        test_sign_msb();
        test_stall();
        test_abort_reset();
        test_extra_start();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/serial_comp.md
# serial_comp

Bit-serial magnitude comparator. It receives two WIDTH-bit operands one bit pair per accepted cycle, MSB first, and reports less/greater/equal flags once the last bit is taken. It sits at the receiving end of serial operand links in the arithmetic datapath. Its flags match the parallel comparators' l/g/e outputs, so downstream logic is unchanged.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; legal range 2..64.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begins a comparison; sampled only in IDLE.
- bit_valid  input  1  a_bit/b_bit hold a valid bit pair this cycle.
- a_bit  input  1  current bit of operand a, MSB first.
- b_bit  input  1  current bit of operand b, MSB first.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result is valid.
- l  output  1  a < b.
- g  output  1  a > b.
- e  output  1  a == b.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - start=1 → RUN; bit counter cleared to 0; relation register set to REL_EQ.
  - bit_valid is ignored in IDLE.
- RUN:
  - Each cycle with bit_valid=1 accepts one bit pair and increments the counter.
  - If the relation is REL_EQ and a_bit≠b_bit, the relation is set to REL_GT if a_bit=1, otherwise REL_LT.
  - Once the relation is decided it is frozen; later bits are still counted but do not change it.
  - On acceptance of bit WIDTH-1 (counter == WIDTH-1 with bit_valid=1) → DONE.
- DONE (one cycle):
  - l, g and e are loaded from the relation.
  - done=1 for this cycle.
  - Next state is IDLE.
- l/g/e hold their last result until the next DONE. Exactly one of them is high after any completed comparison.
- start while in RUN or DONE is ignored; there is no queueing and no abort.
- start and bit_valid high in the same IDLE cycle: that bit pair is not consumed. The first bit is accepted no earlier than the following cycle.
- Counter width is $clog2(WIDTH); it never wraps within a comparison.

## Timing
- Reset values: state IDLE, busy=0, done=0, l=0, g=0, e=0, counter=0, relation REL_EQ.
- Reset acts immediately, even mid-RUN. The partial comparison is discarded and no done is emitted.
- busy rises the cycle after start is sampled and falls on entry to DONE.
- Latency: done is asserted exactly one cycle after the edge that samples the WIDTH-th valid bit pair.
- With bit_valid held high: WIDTH+2 cycles from start sampled to done pulse; minimum repeat interval WIDTH+2.
- Gaps in bit_valid stall the comparison indefinitely; there is no timeout.
- l/g/e change only on the edge entering DONE; they are stable while done=1.

## Configuration
- SERIAL_COMP_SIGNED_EN defined: operands are two's complement. On the first bit (counter==0), a differing pair sets REL_LT if a_bit=1 (a negative), REL_GT if b_bit=1. All remaining bits use the unsigned rule.
- SERIAL_COMP_SIGNED_EN not defined: every bit, including the MSB, uses the unsigned rule.
- Ports, latency and handshake are identical in both builds.

## Structure
- Package serial_comp_pkg holds:
  - state_t enum (IDLE, RUN, DONE).
  - rel_t enum (REL_EQ, REL_LT, REL_GT).
  - Function rel_to_lge(rel_t), returning the {l,g,e} triple.
- There is no sub-module; the FSM, counter and relation register are inline in serial_comp.

## Test plan
- WIDTH=8, a=0xA5, b=0xA5 streamed back-to-back → done on cycle 10 after start; e=1, l=0, g=0.
- Unsigned build: a=0x80, b=0x7F → g=1. Signed build: same operands → l=1.
- a=0x3C, b=0x3D with bit_valid low on cycles 2, 5 and 6 → done is delayed by 3 cycles; l=1.
- rst_n pulsed low after 4 bits of a=0xFF, b=0x00 → busy=0 immediately, no done; l=g=e=0. A fresh compare of a=0x01, b=0x02 afterwards → l=1.
- start reasserted during RUN and start+bit_valid together in IDLE → the extra start has no effect; the first bit pair is dropped and the result reflects only the bits accepted after start.
